// File: rtl/hdng_cmd_seq.sv
// hdng_cmd_seq: command sequencer in front of the heading PID controller.
// Accepts TURN/MOVE commands over valid/ready, drives dsrd_hdng, moving and
// frwrd_spd, and pulses cmd_done on completion. All progress is paced by
// hdng_vld, so the block freezes while the inertial sensor is stalled.
// Optional build macro: HDNG_TIMEOUT_EN adds a turn timeout that pulses
// turn_err; without it turn_err is tied low and a TURN waits indefinitely.
module hdng_cmd_seq #(
  parameter logic [10:0] ACCEL      = 11'h020,
  parameter logic [10:0] DECEL      = 11'h040,
  parameter logic [10:0] MAX_SPD    = 11'h200,
  parameter int          SETTLE_CNT = 4,
  parameter logic [15:0] TURN_TMO   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic        hdng_vld,
  input  logic        at_hdng,
  input  logic        estop,
  output logic [11:0] dsrd_hdng,
  output logic        moving,
  output logic [10:0] frwrd_spd,
  output logic        cmd_done,
  output logic        turn_err
);

  localparam int SW = $clog2(SETTLE_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN, S_RAMP_UP, S_CRUISE, S_RAMP_DN, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [11:0]   r_dsrd_hdng, w_dsrd_nxt;
  logic          r_moving, w_moving_nxt;
  logic [10:0]   r_frwrd_spd, w_spd_nxt;
  logic          r_cmd_done, r_cmd_rdy;
  logic          r_turn_err, w_turn_err_nxt;
  logic [11:0]   r_dist, w_dist_nxt;
  logic [SW-1:0] r_settle, w_settle_nxt;

  logic          w_accept;
  logic [11:0]   w_spd_up;
  logic [10:0]   w_spd_sat;
  logic [10:0]   w_spd_dn;
  logic [11:0]   w_dist_dec;
  logic          w_settled;

`ifdef HDNG_TIMEOUT_EN
  logic [15:0]   r_tmo_cnt, w_tmo_nxt;
  logic          w_unused;
  assign w_unused = ^cmd[13:12];
`else
  logic          w_unused;
  assign w_unused = ^{cmd[13:12], TURN_TMO};
`endif

  // Speed arithmetic: 12-bit add so the ramp cannot wrap before saturating,
  // and a floored subtract so the ramp-down never underflows.
  assign w_accept   = cmd_vld && r_cmd_rdy;
  assign w_spd_up   = {1'b0, r_frwrd_spd} + {1'b0, ACCEL};
  assign w_spd_sat  = (w_spd_up >= {1'b0, MAX_SPD}) ? MAX_SPD : w_spd_up[10:0];
  assign w_spd_dn   = (r_frwrd_spd <= DECEL) ? 11'h000 : (r_frwrd_spd - DECEL);
  assign w_dist_dec = r_dist - 12'd1;
  assign w_settled  = hdng_vld && at_hdng && (r_settle == SW'(SETTLE_CNT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-output decode; estop overrides everything but rst
  always_comb begin
    w_state_nxt    = r_state;
    w_dsrd_nxt     = r_dsrd_hdng;
    w_moving_nxt   = r_moving;
    w_spd_nxt      = r_frwrd_spd;
    w_dist_nxt     = r_dist;
    w_settle_nxt   = r_settle;
    w_turn_err_nxt = 1'b0;
`ifdef HDNG_TIMEOUT_EN
    w_tmo_nxt      = r_tmo_cnt;
`endif
    if (estop) begin
      w_spd_nxt    = 11'h000;
      w_moving_nxt = 1'b0;
      w_state_nxt  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd[15:14])
              2'b01: begin
                w_dsrd_nxt   = cmd[11:0];
                w_moving_nxt = 1'b1;
                w_spd_nxt    = 11'h000;
                w_settle_nxt = '0;
`ifdef HDNG_TIMEOUT_EN
                w_tmo_nxt    = 16'h0000;
`endif
                w_state_nxt  = S_TURN;
              end
              2'b10: begin
                w_dist_nxt   = cmd[11:0];
                w_moving_nxt = 1'b1;
                w_spd_nxt    = 11'h000;
                w_state_nxt  = (cmd[11:0] == 12'h000) ? S_RAMP_DN : S_RAMP_UP;
              end
              default: w_state_nxt = S_DONE;
            endcase
          end
        end
        S_TURN: begin
          if (hdng_vld) begin
            w_settle_nxt = at_hdng ? (r_settle + SW'(1)) : '0;
            if (w_settled) w_state_nxt = S_DONE;
          end
`ifdef HDNG_TIMEOUT_EN
          w_tmo_nxt = r_tmo_cnt + 16'h0001;
          // Settling on the same cycle as the timeout counts as success.
          if (!w_settled && (r_tmo_cnt == (TURN_TMO - 16'h0001))) begin
            w_turn_err_nxt = 1'b1;
            w_moving_nxt   = 1'b0;
            w_state_nxt    = S_IDLE;
          end
`endif
        end
        S_RAMP_UP: begin
          if (hdng_vld) begin
            w_spd_nxt  = w_spd_sat;
            w_dist_nxt = w_dist_dec;
            if (w_dist_dec == 12'h000)  w_state_nxt = S_RAMP_DN;
            else if (w_spd_sat == MAX_SPD) w_state_nxt = S_CRUISE;
          end
        end
        S_CRUISE: begin
          if (hdng_vld) begin
            w_dist_nxt = w_dist_dec;
            if (w_dist_dec == 12'h000) w_state_nxt = S_RAMP_DN;
          end
        end
        S_RAMP_DN: begin
          if (hdng_vld) begin
            w_spd_nxt = w_spd_dn;
            if (w_spd_dn == 11'h000) begin
              w_moving_nxt = 1'b0;
              w_state_nxt  = S_DONE;
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered outputs and working counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dsrd_hdng <= 12'h000;
      r_moving    <= 1'b0;
      r_frwrd_spd <= 11'h000;
      r_cmd_done  <= 1'b0;
      r_cmd_rdy   <= 1'b1;
      r_turn_err  <= 1'b0;
      r_dist      <= 12'h000;
      r_settle    <= '0;
    end else begin
      r_dsrd_hdng <= w_dsrd_nxt;
      r_moving    <= w_moving_nxt;
      r_frwrd_spd <= w_spd_nxt;
      r_cmd_done  <= (w_state_nxt == S_DONE);
      r_cmd_rdy   <= (w_state_nxt == S_IDLE);
      r_turn_err  <= w_turn_err_nxt;
      r_dist      <= w_dist_nxt;
      r_settle    <= w_settle_nxt;
    end
  end

`ifdef HDNG_TIMEOUT_EN
  // Turn timeout cycle counter
  always_ff @(posedge clk) begin
    if (rst) r_tmo_cnt <= 16'h0000;
    else     r_tmo_cnt <= w_tmo_nxt;
  end
`endif

  assign cmd_rdy   = r_cmd_rdy;
  assign dsrd_hdng = r_dsrd_hdng;
  assign moving    = r_moving;
  assign frwrd_spd = r_frwrd_spd;
  assign cmd_done  = r_cmd_done;
  assign turn_err  = r_turn_err;

endmodule

// File: tb/tb_hdng_cmd_seq.sv
// Self-checking bench for hdng_cmd_seq. Expected speed profiles and turn
// completion points are computed from the command rules with plain arithmetic
// over the count of hdng_vld samples seen.
module tb_hdng_cmd_seq;
  localparam int ACC = 32, DEC = 64, MAXS = 512, SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst, cmd_vld, hdng_vld, at_hdng, estop;
  logic [15:0] cmd;
  wire         cmd_rdy, moving, cmd_done, turn_err;
  wire  [11:0] dsrd_hdng;
  wire  [10:0] frwrd_spd;

  int          checks = 0, errors = 0;
  logic [11:0] exp_hdng;
  logic        exp_mov;

  hdng_cmd_seq #(.TURN_TMO(16'd50)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .hdng_vld(hdng_vld), .at_hdng(at_hdng), .estop(estop),
    .dsrd_hdng(dsrd_hdng), .moving(moving), .frwrd_spd(frwrd_spd),
    .cmd_done(cmd_done), .turn_err(turn_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int peak(input int d);
    return (d * ACC < MAXS) ? d * ACC : MAXS;
  endfunction

  // Speed after k hdng_vld samples of a MOVE of distance d.
  function automatic int spd_at(input int d, input int k);
    int v;
    if (k <= d) return (k * ACC < MAXS) ? k * ACC : MAXS;
    v = peak(d) - (k - d) * DEC;
    return (v < 0) ? 0 : v;
  endfunction

  // Number of samples until the MOVE completes.
  function automatic int move_len(input int d);
    int n;
    n = (peak(d) + DEC - 1) / DEC;
    if (n < 1) n = 1;
    return d + n;
  endfunction

  task automatic accept(input logic [15:0] c);
    chk("acc_rdy_pre", cmd_rdy, 1);
    cmd = c; cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0; cmd = 16'($urandom);
  endtask

  task automatic do_move(input int d, input int dens, input int freeze_at, input int estop_at);
    int n, k, cyc;
    bit frz;
    logic [11:0] dd;
    n = move_len(d); k = 0; cyc = 0; frz = 0;
    dd = 12'(d);
    accept({4'b1000, dd});
    chk("mv_acc_rdy", cmd_rdy, 0);
    chk("mv_acc_mov", moving, 1);
    chk("mv_acc_spd", frwrd_spd, 0);
    chk("mv_acc_hdng", dsrd_hdng, exp_hdng);
    while (k < n && cyc < 5000) begin
      if (estop_at > 0 && k == estop_at) begin
        estop = 1'b1; hdng_vld = 1'($urandom_range(0, 1));
        cmd = 16'h4ABC; cmd_vld = 1'b1;
        step();
        estop = 1'b0; cmd_vld = 1'b0;
        chk("es_spd", frwrd_spd, 0);
        chk("es_mov", moving, 0);
        chk("es_rdy", cmd_rdy, 1);
        chk("es_done", cmd_done, 0);
        chk("es_hdng", dsrd_hdng, exp_hdng);
        exp_mov = 1'b0;
        step();
        chk("es_done2", cmd_done, 0);
        chk("es_rdy2", cmd_rdy, 1);
        return;
      end
      if (freeze_at > 0 && k == freeze_at && !frz) begin
        hdng_vld = 1'b0;
        repeat (10) begin
          step();
          chk("mv_frz_spd", frwrd_spd, spd_at(d, k));
        end
        frz = 1;
      end
      hdng_vld = ($urandom_range(0, 99) < dens);
      at_hdng  = 1'($urandom_range(0, 1));
      step();
      cyc++;
      if (hdng_vld) k++;
      chk("mv_spd", frwrd_spd, spd_at(d, k));
      chk("mv_mov", moving, k < n);
      chk("mv_done", cmd_done, k == n);
      chk("mv_rdy", cmd_rdy, 0);
    end
    if (k < n) chk("mv_bound", k, n);
    hdng_vld = 1'b0;
    step();
    chk("mv_post_done", cmd_done, 0);
    chk("mv_post_rdy", cmd_rdy, 1);
    chk("mv_post_mov", moving, 0);
    exp_mov = 1'b0;
  endtask

  task automatic do_turn(input logic [11:0] h, input logic [31:0] pat, input int plen, input int dens);
    bit hist[$];
    bit a, done;
    int cyc;
    done = 0; cyc = 0;
    exp_hdng = h;
    accept({4'b0100, h});
    chk("tn_acc_hdng", dsrd_hdng, h);
    chk("tn_acc_mov", moving, 1);
    chk("tn_acc_rdy", cmd_rdy, 0);
    chk("tn_acc_spd", frwrd_spd, 0);
    while (!done && cyc < 2000) begin
      hdng_vld = ($urandom_range(0, 99) < dens);
      a = (hist.size() < plen) ? pat[hist.size()] : 1'b1;
      at_hdng = hdng_vld ? a : 1'($urandom_range(0, 1));
      step();
      cyc++;
      if (hdng_vld) begin
        hist.push_back(a);
        if (hist.size() >= SETTLE) begin
          done = 1;
          for (int i = hist.size() - SETTLE; i < hist.size(); i++)
            if (!hist[i]) done = 0;
        end
      end
      chk("tn_hdng", dsrd_hdng, h);
      chk("tn_mov", moving, 1);
      chk("tn_spd", frwrd_spd, 0);
      chk("tn_done", cmd_done, done);
      chk("tn_err", turn_err, 0);
      chk("tn_rdy", cmd_rdy, 0);
    end
    if (!done) chk("tn_bound", cyc, 2000 + 1);
    hdng_vld = 1'b0;
    step();
    chk("tn_post_done", cmd_done, 0);
    chk("tn_post_rdy", cmd_rdy, 1);
    chk("tn_post_mov", moving, 1);
    exp_mov = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cmd = 16'h0000; cmd_vld = 1'b0; hdng_vld = 1'b0;
    at_hdng = 1'b0; estop = 1'b0;
    exp_hdng = 12'h000; exp_mov = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_rdy", cmd_rdy, 1);
    chk("rst_mov", moving, 0);
    chk("rst_spd", frwrd_spd, 0);
    chk("rst_hdng", dsrd_hdng, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_err", turn_err, 0);

    // Turn: first sample off heading, then settled
    do_turn(12'h3FF, 32'hFFFF_FFFE, 32, 100);
    // Turn: at_hdng drops after three good samples
    do_turn(12'h155, 32'hFFFF_FFF7, 32, 100);
    // Full move profile, then one frozen mid-ramp
    do_move(32, 100, 0, 0);
    do_move(32, 100, 8, 0);
    // NOP and reserved opcodes finish immediately without touching outputs
    accept(16'h0123);
    chk("nop_done", cmd_done, 1);
    chk("nop_rdy", cmd_rdy, 0);
    chk("nop_mov", moving, exp_mov);
    chk("nop_hdng", dsrd_hdng, exp_hdng);
    step();
    chk("nop_done2", cmd_done, 0);
    chk("nop_rdy2", cmd_rdy, 1);
    accept(16'hCABC);
    chk("rsv_done", cmd_done, 1);
    chk("rsv_spd", frwrd_spd, 0);
    step();
    chk("rsv_done2", cmd_done, 0);
    // Randomised moves and turns
    repeat (4) do_move(int'($urandom_range(0, 40)), int'($urandom_range(30, 100)), 0, 0);
    repeat (3) do_turn(12'($urandom), 32'($urandom), 8, int'($urandom_range(80, 100)));
    do_move(int'($urandom_range(1, 12)), 100, 0, 0);
    // estop during cruise
    do_move(100, 100, 0, 20);
    // estop while a command is presented in IDLE
    do_turn(12'h0A5, 32'hFFFF_FFFF, 4, 100);
    cmd = 16'h4777; cmd_vld = 1'b1; estop = 1'b1;
    step();
    cmd_vld = 1'b0; estop = 1'b0;
    chk("esi_rdy", cmd_rdy, 1);
    chk("esi_hdng", dsrd_hdng, exp_hdng);
    chk("esi_mov", moving, 0);
    chk("esi_done", cmd_done, 0);
    exp_mov = 1'b0;
    // Zero-distance move
    do_move(0, 100, 0, 0);
    // Reset in the middle of a turn
    accept(16'h4777);
    hdng_vld = 1'b1; at_hdng = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0; hdng_vld = 1'b0;
    exp_hdng = 12'h000; exp_mov = 1'b0;
    chk("mrst_hdng", dsrd_hdng, 0);
    chk("mrst_mov", moving, 0);
    chk("mrst_rdy", cmd_rdy, 1);
    chk("mrst_done", cmd_done, 0);
    // Turn that never settles
    accept(16'h4246);
`ifdef HDNG_TIMEOUT_EN
    for (int c = 1; c <= 50; c++) begin
      hdng_vld = 1'($urandom_range(0, 1)); at_hdng = 1'b0;
      step();
      chk("tmo_err", turn_err, c == 50);
      chk("tmo_mov", moving, c < 50);
      chk("tmo_rdy", cmd_rdy, c == 50);
      chk("tmo_done", cmd_done, 0);
    end
    step();
    chk("tmo_err2", turn_err, 0);
    chk("tmo_done2", cmd_done, 0);
`else
    for (int c = 1; c <= 60; c++) begin
      hdng_vld = 1'($urandom_range(0, 1)); at_hdng = 1'b0;
      step();
      chk("ntmo_err", turn_err, 0);
      chk("ntmo_rdy", cmd_rdy, 0);
      chk("ntmo_mov", moving, 1);
    end
    estop = 1'b1;
    step();
    estop = 1'b0;
    chk("ntmo_es_rdy", cmd_rdy, 1);
    chk("ntmo_es_mov", moving, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
